// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter with break-before-make grant gaps.
// Registered one-hot grant plus index; a grant is held until the owner drops
// its request or, with other requesters waiting, until MAX_HOLD cycles elapse.
// Optional build macro RR_ARBITER8_LOCK_EN adds a lock input that suspends the
// hold timeout while asserted during a grant.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner, arbitrating every cycle from the priority pointer
// S_GRANT | one owner holds the resource, hold counter running
// S_GAP   | single idle cycle after a release; previous owner has lowest priority
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
`ifdef RR_ARBITER8_LOCK_EN
   input  logic       lock,
`endif
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid
);

   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    gnt_q, gnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          valid_q, valid_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          win_found;
   logic [2:0]    win_idx;
   logic          lock_act;
   logic          others_pending;
   logic          owner_req;

`ifdef RR_ARBITER8_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   // The owner's own bit is masked out so only genuine competitors can preempt.
   assign others_pending = |(req & ~gnt_q);
   assign owner_req      = req[idx_q];

   // Rotating priority search: ptr+1 first, ptr itself last.
   always_comb begin
      logic [2:0] cand;
      cand      = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= 8; k++) begin
         cand = ptr_q + 3'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and registered-output decisions.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_GAP: begin
            if (win_found) begin
               state_d = S_GRANT;
               gnt_d   = 8'b1 << win_idx;
               idx_d   = win_idx;
               valid_d = 1'b1;
               ptr_d   = win_idx;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
            end
         end
         S_GRANT: begin
            // A release wins over a coincident timeout; both end in the gap.
            if (!owner_req || (!lock_act && cnt_q == CNT_MAX && others_pending)) begin
               state_d = S_GAP;
               gnt_d   = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end else if (lock_act) begin
               cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers; reset clears the grant without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= 3'd7;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: the driver steps a behavioural ownership
// model on every applied request vector and queues the expected outputs; a
// monitor pops and compares one entry per clock while reset is low.
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] req = 8'h00;
`ifdef RR_ARBITER8_LOCK_EN
   logic       lock = 1'b0;
`endif
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] g;
      logic [2:0] i;
      logic       v;
   } exp_t;

   exp_t sbq[$];

   // Reference model: who owns the resource, who owned it last, how long held.
   int m_owner = -1;
   int m_ptr   = 7;
   int m_held  = 0;
   int m_idx   = 0;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
`ifdef RR_ARBITER8_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always #5 clk = ~clk;

   function automatic int rr_pick(int p, logic [7:0] r);
      for (int k = 1; k <= 8; k++) begin
         int c;
         c = (p + k) % 8;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 7;
      m_held  = 0;
      m_idx   = 0;
   endtask

   task automatic model_step(input logic [7:0] r);
      logic [7:0] others;
      int         w;
      exp_t       e;
      if (m_owner >= 0) begin
         others = r;
         others[m_owner] = 1'b0;
         if (!r[m_owner] || (m_held >= MAX_HOLD && others != 8'h00)) m_owner = -1;
         else m_held++;
      end else begin
         w = rr_pick(m_ptr, r);
         if (w >= 0) begin
            m_owner = w;
            m_ptr   = w;
            m_idx   = w;
            m_held  = 1;
         end
      end
      e.g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      e.i = 3'(m_idx);
      e.v = (m_owner >= 0);
      sbq.push_back(e);
   endtask

   task automatic drive(input logic [7:0] r);
      @(negedge clk);
      req = r;
      model_step(r);
   endtask

   task automatic release_rst(input logic [7:0] r);
      @(negedge clk);
      rst = 1'b0;
      req = r;
      model_step(r);
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
         errors++;
         $display("FAIL %s: got gnt=%h idx=%0d valid=%b, need gnt=00 idx=0 valid=0",
                  tag, gnt, gnt_idx, gnt_valid);
      end
   endtask

   // Monitor: one expected entry per clock edge taken out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow: DUT output gnt=%h with no expected entry", gnt);
            end else begin
               e = sbq.pop_front();
               if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
                  errors++;
                  $display("FAIL grant_out @%0t: got gnt=%h idx=%0d valid=%b, need gnt=%h idx=%0d valid=%b",
                           $time, gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      #1 rst = 1'b1;
      #3 check_reset_outputs("reset_initial");
      model_reset();
      @(negedge clk);
      release_rst(8'h00);
      repeat (2) drive(8'h00);

      // single requester 5
      repeat (3) drive(8'h20);
      repeat (3) drive(8'h00);

      // round robin: owner drops its bit right after being granted
      for (int n = 0; n < 34; n++) begin
         r = 8'hFF;
         if (m_owner >= 0) r[m_owner] = 1'b0;
         drive(r);
      end
      repeat (2) drive(8'h00);

      // hold timeout between two requesters
      repeat (30) drive(8'h03);
      repeat (2) drive(8'h00);

      // no contention: owner keeps the grant past the timeout
      repeat (50) drive(8'h10);
      drive(8'h00);

      // randomized traffic with sticky request vectors
      r = 8'h00;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(3) == 0) r = 8'($urandom);
         if ($urandom_range(15) == 0) r = 8'h00;
         drive(r);
      end
      repeat (2) drive(8'h00);

      // reset mid-grant of requester 3
      repeat (3) drive(8'h08);
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_outputs("reset_async_midgrant");
      model_reset();
      @(negedge clk);
      check_reset_outputs("reset_held");
      release_rst(8'hFF);
      repeat (20) begin
         r = 8'hFF;
         if (m_owner >= 0) r[m_owner] = 1'b0;
         drive(r);
      end
      repeat (2) drive(8'h00);

      @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected entries left, need 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
